// File: rtl/wb_ctrl_pkg.sv
// Shared processor definitions for the writeback controller: register count,
// field widths, write-lane encodings and the result record held in the load buffer.
package wb_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 6;
  localparam int PPP_W    = 3;
  localparam int DATA_W   = 64;
  localparam int REQ_W    = ADDR_W + PPP_W + DATA_W;

  typedef enum logic [PPP_W-1:0] {
    PPP_FULL  = 3'b000,
    PPP_UPPER = 3'b001,
    PPP_LOWER = 3'b010,
    PPP_EVEN  = 3'b011,
    PPP_ODD   = 3'b100
  } ppp_e;

  typedef struct packed {
    logic [0:ADDR_W-1] addr;
    logic [0:PPP_W-1]  ppp;
    logic [0:DATA_W-1] data;
  } wb_req_t;

  function automatic logic ppp_legal(input logic [0:PPP_W-1] p);
    return p <= PPP_ODD;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular load-result buffer: arrival order preserved, pointers wrap at DEPTH.
module wb_fifo
  import wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REQ_W-1:0] din,
  input  logic             pop,
  output logic [REQ_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU results, buffered loads and load bypass
// onto one registered register-file write port, and tracks pending destinations.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int NREG      = NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [0:ADDR_W-1] alu_addr,
  input  logic [0:PPP_W-1]  alu_ppp,
  input  logic [0:DATA_W-1] alu_data,
  input  logic              mem_valid,
  input  logic [0:ADDR_W-1] mem_addr,
  input  logic [0:PPP_W-1]  mem_ppp,
  input  logic [0:DATA_W-1] mem_data,
  output logic              mem_ready,
  input  logic              issue_en,
  input  logic [0:ADDR_W-1] issue_addr,
  input  logic [0:ADDR_W-1] chk_a,
  input  logic [0:ADDR_W-1] chk_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              rf_wr_en,
  output logic [0:PPP_W-1]  rf_ppp,
  output logic [0:ADDR_W-1] rf_in_addr,
  output logic [0:DATA_W-1] rf_in_data,
  output logic              err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  wb_req_t          alu_req;
  wb_req_t          mem_req;
  wb_req_t          head_req;
  wb_req_t          sel_req_p0;
  logic             sel_vld_p0;
  logic             err_p0;
  logic             alu_ok;
  logic             mem_ok;
  logic             sel_head;
  logic             sel_byp;
  logic             fifo_push;
  logic [REQ_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [NREG-1:0]  pending;

  // Address 0 is a silent no-op; out-of-range addresses and lane codes are errors.
  function automatic logic is_legal(input logic [0:ADDR_W-1] a, input logic [0:PPP_W-1] p);
    return (a != '0) && (a < ADDR_W'(NREG)) && ppp_legal(p);
  endfunction

  function automatic logic is_bad(input logic [0:ADDR_W-1] a, input logic [0:PPP_W-1] p);
    return (a != '0) && ((a >= ADDR_W'(NREG)) || !ppp_legal(p));
  endfunction

  function automatic logic busy_of(input logic [0:ADDR_W-1] c, input logic [NREG-1:0] pend,
                                   input logic wr, input logic [0:ADDR_W-1] wa);
    logic b;
    b = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (c == ADDR_W'(i)) b = pend[i];
    if (wr && (wa == c)) b = 1'b1;
    if (c == '0) b = 1'b0;
    return b;
  endfunction

  assign alu_req   = {alu_addr, alu_ppp, alu_data};
  assign mem_req   = {mem_addr, mem_ppp, mem_data};
  assign head_req  = fifo_dout;
  assign mem_ready = (fifo_count < CNT_W'(BUF_DEPTH));

  // Stage p0: pick one write for this cycle.
  always_comb begin
    alu_ok     = alu_valid && is_legal(alu_addr, alu_ppp);
    mem_ok     = mem_valid && mem_ready && is_legal(mem_addr, mem_ppp);
    sel_head   = !alu_ok && !fifo_empty;
    sel_byp    = !alu_ok && fifo_empty && mem_ok;
    fifo_push  = mem_ok && !sel_byp && !fifo_full;
    sel_vld_p0 = alu_ok || sel_head || sel_byp;
    err_p0     = (alu_valid && is_bad(alu_addr, alu_ppp))
               || (mem_valid && !mem_ready)
               || (mem_valid && mem_ready && is_bad(mem_addr, mem_ppp));
    sel_req_p0 = alu_req;
    if (sel_head)     sel_req_p0 = head_req;
    else if (sel_byp) sel_req_p0 = mem_req;
  end

  wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (mem_req),
    .pop   (sel_head),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p1: registered register-file port; lanes/address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_ppp     <= '0;
      rf_in_addr <= '0;
      rf_in_data <= '0;
      err        <= 1'b0;
    end else begin
      rf_wr_en <= sel_vld_p0;
      err      <= err_p0;
      if (sel_vld_p0) begin
        rf_ppp     <= sel_req_p0.ppp;
        rf_in_addr <= sel_req_p0.addr;
        rf_in_data <= sel_req_p0.data;
      end
    end
  end

  // Issue beats a simultaneous writeback clear to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (issue_en && (issue_addr == ADDR_W'(i)))
          pending[i] <= 1'b1;
        else if (rf_wr_en && (rf_in_addr == ADDR_W'(i)))
          pending[i] <= 1'b0;
      end
    end
  end

  assign busy_a = busy_of(chk_a, pending, rf_wr_en, rf_in_addr);
  assign busy_b = busy_of(chk_b, pending, rf_wr_en, rf_in_addr);

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios then random traffic, all checked
// against a queue-based transaction model of the writeback rules.
module tb_wb_ctrl;

  localparam int BUF_DEPTH = 2;
  localparam int NREG      = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [0:5]  alu_addr;
  logic [0:2]  alu_ppp;
  logic [0:63] alu_data;
  logic        mem_valid;
  logic [0:5]  mem_addr;
  logic [0:2]  mem_ppp;
  logic [0:63] mem_data;
  logic        mem_ready;
  logic        issue_en;
  logic [0:5]  issue_addr;
  logic [0:5]  chk_a;
  logic [0:5]  chk_b;
  logic        busy_a;
  logic        busy_b;
  logic        rf_wr_en;
  logic [0:2]  rf_ppp;
  logic [0:5]  rf_in_addr;
  logic [0:63] rf_in_data;
  logic        err;

  always #5 clk = ~clk;

  wb_ctrl #(.BUF_DEPTH(BUF_DEPTH), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_ppp    (alu_ppp),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_ppp    (mem_ppp),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .chk_a      (chk_a),
    .chk_b      (chk_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .rf_wr_en   (rf_wr_en),
    .rf_ppp     (rf_ppp),
    .rf_in_addr (rf_in_addr),
    .rf_in_data (rf_in_data),
    .err        (err)
  );

  typedef struct {
    int          addr;
    int          ppp;
    logic [63:0] data;
  } req_t;

  req_t        q[$];
  bit          pend[NREG];
  bit          e_wr;
  bit          e_err;
  int          e_addr;
  int          e_ppp;
  logic [63:0] e_data;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(int a, int p);
    return a != 0 && a < NREG && p <= 4;
  endfunction

  function automatic bit illegal_err(int a, int p);
    return a != 0 && (a >= NREG || p > 4);
  endfunction

  function automatic bit exp_busy(int c);
    if (c == 0 || c >= NREG) return 1'b0;
    return pend[c] || (e_wr && e_addr == c);
  endfunction

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    issue_en  = 1'b0;
  endtask

  task automatic set_alu(input int a, input int p, input logic [63:0] d);
    alu_valid = 1'b1;
    alu_addr  = 6'(a);
    alu_ppp   = 3'(p);
    alu_data  = d;
  endtask

  task automatic set_mem(input int a, input int p, input logic [63:0] d);
    mem_valid = 1'b1;
    mem_addr  = 6'(a);
    mem_ppp   = 3'(p);
    mem_data  = d;
  endtask

  // Advance the model by one cycle of the current inputs, clock, then compare.
  task automatic step();
    req_t w;
    bit   found;
    bit   acc;
    bit   mr;
    int   aa, ap, ma, mp, ia;
    aa = int'(alu_addr);
    ap = int'(alu_ppp);
    ma = int'(mem_addr);
    mp = int'(mem_ppp);
    ia = int'(issue_addr);
    if (rst) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      e_wr = 1'b0; e_err = 1'b0; e_addr = 0; e_ppp = 0; e_data = '0;
    end else begin
      mr    = q.size() < BUF_DEPTH;
      e_err = (alu_valid && illegal_err(aa, ap)) || (mem_valid && !mr)
            || (mem_valid && mr && illegal_err(ma, mp));
      acc   = mem_valid && mr && legal(ma, mp);
      found = 1'b0;
      if (alu_valid && legal(aa, ap)) begin
        w = '{aa, ap, alu_data}; found = 1'b1;
      end else if (q.size() > 0) begin
        w = q.pop_front(); found = 1'b1;
      end else if (acc) begin
        w = '{ma, mp, mem_data}; found = 1'b1; acc = 1'b0;
      end
      if (acc) q.push_back('{ma, mp, mem_data});
      if (e_wr) pend[e_addr] = 1'b0;
      if (issue_en && ia != 0 && ia < NREG) pend[ia] = 1'b1;
      e_wr = found;
      if (found) begin
        e_addr = w.addr; e_ppp = w.ppp; e_data = w.data;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_wr_en",   64'(rf_wr_en),   64'(e_wr));
    chk("rf_ppp",     64'(rf_ppp),     64'(e_ppp));
    chk("rf_in_addr", 64'(rf_in_addr), 64'(e_addr));
    chk("rf_in_data", 64'(rf_in_data), e_data);
    chk("err",        64'(err),        64'(e_err));
    chk("mem_ready",  64'(mem_ready),  64'(q.size() < BUF_DEPTH));
    chk("busy_a",     64'(busy_a),     64'(exp_busy(int'(chk_a))));
    chk("busy_b",     64'(busy_b),     64'(exp_busy(int'(chk_b))));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    alu_addr = '0; alu_ppp = '0; alu_data = '0;
    mem_addr = '0; mem_ppp = '0; mem_data = '0;
    issue_addr = '0; chk_a = 6'd9; chk_b = 6'd7;

    // Reset with garbage on the inputs
    set_alu(4, 0, 64'h1234); set_mem(6, 1, 64'h5678); issue_en = 1'b1; issue_addr = 6'd7;
    step();
    step();
    chk("reset_ready", 64'(mem_ready), 64'd1);
    rst = 1'b0;
    idle();
    step();

    // ALU-only write
    set_alu(5, 0, 64'hDEAD);
    step();
    idle();
    chk("alu_only_addr", 64'(rf_in_addr), 64'd5);
    chk("alu_only_data", rf_in_data, 64'hDEAD);
    step();
    chk("alu_only_idle", 64'(rf_wr_en), 64'd0);

    // Collision: ALU first, load next cycle
    set_alu(3, 1, 64'hAAAA); set_mem(7, 2, 64'h7777);
    step();
    idle();
    chk("coll_first", 64'(rf_in_addr), 64'd3);
    step();
    chk("coll_second", 64'(rf_in_addr), 64'd7);
    step();

    // Full buffer: third load dropped, buffered loads drain in order
    for (int i = 0; i < 3; i++) begin
      set_alu(10 + i, 0, 64'(100 + i)); set_mem(20 + i, 3, 64'(200 + i));
      step();
    end
    chk("full_err", 64'(err), 64'd1);
    idle();
    step();
    chk("drain_0", 64'(rf_in_addr), 64'd20);
    step();
    chk("drain_1", 64'(rf_in_addr), 64'd21);
    step();

    // Scoreboard set, in-flight busy, clear, set-wins
    chk_a = 6'd9; chk_b = 6'd0;
    issue_en = 1'b1; issue_addr = 6'd9;
    step();
    idle();
    chk("sb_set", 64'(busy_a), 64'd1);
    set_alu(9, 4, 64'h99);
    step();
    idle();
    chk("sb_inflight", 64'(busy_a), 64'd1);
    step();
    chk("sb_clear", 64'(busy_a), 64'd0);
    issue_en = 1'b1; issue_addr = 6'd9;
    step();
    set_alu(9, 0, 64'h98); issue_en = 1'b0;
    step();
    idle();
    issue_en = 1'b1; issue_addr = 6'd9;
    step();
    idle();
    chk("sb_set_wins", 64'(busy_a), 64'd1);

    // Illegal requests
    set_alu(0, 0, 64'h1);
    step();
    chk("addr0_silent", 64'(err), 64'd0);
    set_alu(40, 0, 64'h2);
    step();
    chk("addr40_err", 64'(err), 64'd1);
    set_alu(6, 6, 64'h3);
    step();
    chk("ppp110_err", 64'(err), 64'd1);
    idle();
    step();

    // Reset while two loads are buffered
    for (int i = 0; i < 2; i++) begin
      set_alu(12, 0, 64'h5); set_mem(14 + i, 0, 64'h6);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    chk("rst_mid_ready", 64'(mem_ready), 64'd1);
    rst = 1'b0;
    step();
    chk("rst_no_stale", 64'(rf_wr_en), 64'd0);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      alu_valid = ($urandom_range(0, 99) < 45);
      mem_valid = ($urandom_range(0, 99) < 55);
      issue_en  = ($urandom_range(0, 99) < 40);
      alu_addr  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      mem_addr  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      alu_ppp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      mem_ppp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      alu_data  = {$urandom, $urandom};
      mem_data  = {$urandom, $urandom};
      issue_addr = 6'($urandom_range(0, 35));
      chk_a     = 6'($urandom_range(0, 33));
      chk_b     = 6'($urandom_range(0, 33));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
